tcp_rt_timer: RTL

Sender-side retransmission trigger for the slow-path TCP engine. Tracks per-flow acknowledgement progress arriving from the RX path, keeps one retransmit deadline per flow, and issues retransmit requests to the TX engine on timeout or on duplicate-ACK threshold. It sits between RX ACK processing and TX segment generation, and consumes the ACK/sequence state the receive side produces.

---
 rtl/tcp_pkg.sv | 56 +++++
 rtl/tcp_rt_scan.sv | 74 +++++++
 rtl/tcp_rt_timer.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/tcp_pkg.sv
// ============================================================================
// Module      : tcp_pkg
// Description : Shared types and constants for the TCP slow-path engine.
//               Adds the per-flow retransmit timer state and the retransmit
//               request record used by tcp_rt_timer / tcp_rt_scan.
//               Optional macro: TCP_RT_FAST_RETX_EN enables duplicate-ACK
//               counting (dup_cnt / pend_fast fields).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef ACK_NUM_W
`define ACK_NUM_W 32
`endif
`ifndef SEQ_NUM_W
`define SEQ_NUM_W 32
`endif

package tcp_pkg;

    localparam int MAX_FLOW_CNT      = 4;
    localparam int RT_TIMEOUT_CYCLES = 1000;
    localparam int RT_ACK_THRESHOLD  = 3;
    localparam int TIMESTAMP_W       = 64;
    // Wider than the threshold needs so a saturated count never re-matches it.
    localparam int DUP_ACK_CNT_W     = 3;
    localparam int RT_FLOWID_W       = $clog2(MAX_FLOW_CNT);

    // Per-flow acknowledgement progress.
    typedef struct packed {
        logic [`ACK_NUM_W-1:0]    last_ack;
`ifdef TCP_RT_FAST_RETX_EN
        logic [DUP_ACK_CNT_W-1:0] dup_cnt;
`endif
    } ack_state_struct;

    // Per-flow retransmit deadline and pending-request flags.
    typedef struct packed {
        logic [TIMESTAMP_W-1:0] deadline;
        logic                   armed;
        logic                   pend;
`ifdef TCP_RT_FAST_RETX_EN
        logic                   pend_fast;
`endif
    } rt_flow_timer_struct;

    // Retransmit request handed to the TX engine.
    typedef struct packed {
        logic [RT_FLOWID_W-1:0] flowid;
        logic [`SEQ_NUM_W-1:0]  seq;
        logic                   fast;
    } rt_req_struct;

endpackage

`default_nettype wire

// File: rtl/tcp_rt_scan.sv
// ============================================================================
// Module      : tcp_rt_scan
// Description : Round-robin scanner for tcp_rt_timer. Visits one flow per
//               cycle, flags deadline expiry, and loads the retransmit
//               request output register from a pending flow.
//               Optional macro: TCP_RT_FAST_RETX_EN (carries pend_fast out).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tcp_rt_scan
    import tcp_pkg::*;
#(
    parameter int FLOW_CNT = MAX_FLOW_CNT,
    parameter int FLOWID_W = $clog2(FLOW_CNT),
    parameter int TS_W     = TIMESTAMP_W
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic [TS_W-1:0]                           i_now,
    input  rt_flow_timer_struct [FLOW_CNT-1:0]        i_timers,
    input  logic [FLOW_CNT-1:0][`ACK_NUM_W-1:0]       i_last_ack,
    input  logic                                      i_rt_req_rdy,
    output logic [FLOWID_W-1:0]                       o_ptr,
    output logic                                      o_expire,
    output logic                                      o_load,
    output logic                                      o_req_val,
    output rt_req_struct                              o_req
);

    logic [FLOWID_W-1:0] r_ptr;
    logic                r_req_val;
    rt_req_struct        r_req;
    rt_flow_timer_struct w_cur;
    logic                w_fast;

    assign w_cur = i_timers[r_ptr];

`ifdef TCP_RT_FAST_RETX_EN
    assign w_fast = w_cur.pend_fast;
`else
    assign w_fast = 1'b0;
`endif

    // Expiry wins over load on the same visit; the load happens next visit.
    assign o_expire = w_cur.armed && (i_now >= TS_W'(w_cur.deadline));
    assign o_load   = w_cur.pend && !o_expire && (!r_req_val || i_rt_req_rdy);

    // Advance the scan pointer and manage the request output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr     <= '0;
            r_req_val <= 1'b0;
            r_req     <= '0;
        end else begin
            r_ptr <= (r_ptr == FLOWID_W'(FLOW_CNT - 1)) ? '0 : r_ptr + 1'b1;
            if (o_load) begin
                r_req_val   <= 1'b1;
                r_req.flowid <= RT_FLOWID_W'(r_ptr);
                r_req.seq    <= `SEQ_NUM_W'(i_last_ack[r_ptr]);
                r_req.fast   <= w_fast;
            end else if (i_rt_req_rdy) begin
                r_req_val <= 1'b0;
            end
        end
    end

    assign o_ptr     = r_ptr;
    assign o_req_val = r_req_val;
    assign o_req     = r_req;

endmodule

`default_nettype wire

// File: rtl/tcp_rt_timer.sv
// ============================================================================
// Module      : tcp_rt_timer
// Description : Sender-side retransmission trigger. Tracks per-flow ACK
//               progress, keeps one retransmit deadline per flow and raises
//               retransmit requests on timeout or duplicate-ACK threshold.
//               Optional macro: TCP_RT_FAST_RETX_EN enables fast retransmit
//               on duplicate ACKs; without it only timeouts are reported.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tcp_rt_timer
    import tcp_pkg::*;
#(
    parameter int FLOW_CNT       = MAX_FLOW_CNT,
    parameter int FLOWID_W       = $clog2(FLOW_CNT),
    parameter int TIMEOUT_CYCLES = RT_TIMEOUT_CYCLES,
    parameter int DUP_THRESH     = RT_ACK_THRESHOLD,
    parameter int TS_W           = TIMESTAMP_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_init_val,
    input  logic [FLOWID_W-1:0]     i_init_flowid,
    input  logic [`ACK_NUM_W-1:0]   i_init_ack,
    input  logic                    i_arm_val,
    input  logic [FLOWID_W-1:0]     i_arm_flowid,
    output logic                    o_arm_rdy,
    input  logic                    i_ack_val,
    input  logic [FLOWID_W-1:0]     i_ack_flowid,
    input  logic [`ACK_NUM_W-1:0]   i_ack_num,
    input  logic [`SEQ_NUM_W-1:0]   i_ack_snd_nxt,
    output logic                    o_ack_rdy,
    output logic                    o_rt_req_val,
    output logic [FLOWID_W-1:0]     o_rt_req_flowid,
    output logic [`SEQ_NUM_W-1:0]   o_rt_req_seq,
    output logic                    o_rt_req_fast,
    input  logic                    i_rt_req_rdy
);

    ack_state_struct     [FLOW_CNT-1:0]             r_ack_st, w_ack_nxt;
    rt_flow_timer_struct [FLOW_CNT-1:0]             r_tmr, w_tmr_nxt;
    logic                [FLOW_CNT-1:0][`ACK_NUM_W-1:0] w_last_ack;
    logic [TS_W-1:0]        r_now;
    logic                   r_rdy;
    logic [TIMESTAMP_W-1:0] w_new_deadline;
    ack_state_struct        w_ack_cur;
    logic [`ACK_NUM_W-1:0]  w_diff, w_win;
    logic                   w_adv, w_ack_fire, w_arm_fire;
    logic [FLOWID_W-1:0]    w_scan_ptr;
    logic                   w_scan_exp, w_scan_load;
    rt_req_struct           w_req;
`ifdef TCP_RT_FAST_RETX_EN
    logic                   w_dup;
    logic [DUP_ACK_CNT_W-1:0] w_dup_new;
`endif

    // ACK classification uses modular distances from the flow's last_ack.
    assign w_ack_cur      = r_ack_st[i_ack_flowid];
    assign w_diff         = i_ack_num - w_ack_cur.last_ack;
    assign w_win          = `ACK_NUM_W'(i_ack_snd_nxt) - w_ack_cur.last_ack;
    assign w_adv          = (w_diff != '0) && (w_diff <= w_win);
    assign w_ack_fire     = i_ack_val && r_rdy && !(i_init_val && i_init_flowid == i_ack_flowid);
    assign w_arm_fire     = i_arm_val && r_rdy && !(i_init_val && i_init_flowid == i_arm_flowid);
    assign w_new_deadline = TIMESTAMP_W'(r_now + TS_W'(TIMEOUT_CYCLES));

`ifdef TCP_RT_FAST_RETX_EN
    assign w_dup     = (w_diff == '0) && (w_win != '0);
    assign w_dup_new = (w_ack_cur.dup_cnt == '1) ? w_ack_cur.dup_cnt : w_ack_cur.dup_cnt + 1'b1;
`endif

    generate
        for (genvar g = 0; g < FLOW_CNT; g++) begin : g_last_ack
            assign w_last_ack[g] = r_ack_st[g].last_ack;
        end
    endgenerate

    // Next flow state: scan effects, then ACK, then arm, then init (highest).
    always_comb begin
        w_ack_nxt = r_ack_st;
        w_tmr_nxt = r_tmr;
        if (w_scan_exp) begin
            w_tmr_nxt[w_scan_ptr].armed = 1'b0;
            w_tmr_nxt[w_scan_ptr].pend  = 1'b1;
        end else if (w_scan_load) begin
            w_tmr_nxt[w_scan_ptr].pend  = 1'b0;
`ifdef TCP_RT_FAST_RETX_EN
            w_tmr_nxt[w_scan_ptr].pend_fast = 1'b0;
`endif
        end
        if (w_ack_fire) begin
            if (w_adv) begin
                w_ack_nxt[i_ack_flowid].last_ack = i_ack_num;
                w_tmr_nxt[i_ack_flowid].pend     = 1'b0;
`ifdef TCP_RT_FAST_RETX_EN
                w_ack_nxt[i_ack_flowid].dup_cnt   = '0;
                w_tmr_nxt[i_ack_flowid].pend_fast = 1'b0;
`endif
                if (i_ack_num == `ACK_NUM_W'(i_ack_snd_nxt)) begin
                    w_tmr_nxt[i_ack_flowid].armed = 1'b0;
                end else begin
                    w_tmr_nxt[i_ack_flowid].armed    = 1'b1;
                    w_tmr_nxt[i_ack_flowid].deadline = w_new_deadline;
                end
            end
`ifdef TCP_RT_FAST_RETX_EN
            else if (w_dup) begin
                w_ack_nxt[i_ack_flowid].dup_cnt = w_dup_new;
                if (w_dup_new == DUP_ACK_CNT_W'(DUP_THRESH)) begin
                    w_tmr_nxt[i_ack_flowid].pend      = 1'b1;
                    w_tmr_nxt[i_ack_flowid].pend_fast = 1'b1;
                end
            end
`endif
        end
        if (w_arm_fire && !w_tmr_nxt[i_arm_flowid].armed) begin
            w_tmr_nxt[i_arm_flowid].armed    = 1'b1;
            w_tmr_nxt[i_arm_flowid].deadline = w_new_deadline;
        end
        if (i_init_val) begin
            w_ack_nxt[i_init_flowid]          = '0;
            w_ack_nxt[i_init_flowid].last_ack = i_init_ack;
            w_tmr_nxt[i_init_flowid]          = '0;
        end
    end

    // Flow state, time base and accept flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ack_st <= '0;
            r_tmr    <= '0;
            r_now    <= '0;
            r_rdy    <= 1'b0;
        end else begin
            r_ack_st <= w_ack_nxt;
            r_tmr    <= w_tmr_nxt;
            r_now    <= r_now + 1'b1;
            r_rdy    <= 1'b1;
        end
    end

    tcp_rt_scan #(
        .FLOW_CNT (FLOW_CNT),
        .FLOWID_W (FLOWID_W),
        .TS_W     (TS_W)
    ) u_scan (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_now        (r_now),
        .i_timers     (r_tmr),
        .i_last_ack   (w_last_ack),
        .i_rt_req_rdy (i_rt_req_rdy),
        .o_ptr        (w_scan_ptr),
        .o_expire     (w_scan_exp),
        .o_load       (w_scan_load),
        .o_req_val    (o_rt_req_val),
        .o_req        (w_req)
    );

    assign o_arm_rdy       = r_rdy;
    assign o_ack_rdy       = r_rdy;
    assign o_rt_req_flowid = FLOWID_W'(w_req.flowid);
    assign o_rt_req_seq    = w_req.seq;
    assign o_rt_req_fast   = w_req.fast;

endmodule

`default_nettype wire
